// File: rtl/led_matrix_scan_pkg.sv
// Shared constants, index typedefs and the pattern ROM for the LED matrix scanner.
package led_matrix_pkg;

    localparam int MATRIX_ROWS  = 8;
    localparam int MATRIX_COLS  = 8;
    localparam int NUM_PATTERNS = 4;

    typedef logic [2:0] row_idx_t;
    typedef logic [1:0] pat_sel_t;
    typedef logic [MATRIX_COLS-1:0] col_word_t;

    // P0 diagonal, P1 full, P2 checker, P3 border; element [p][r] is row r of pattern p
    localparam col_word_t PATTERN_ROM [NUM_PATTERNS][MATRIX_ROWS] = '{
        '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80},
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55},
        '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF}
    };

endpackage

// File: rtl/led_matrix_scan_if.sv
// Pattern select in, row/column drive and frame status out of the LED matrix scanner.
interface led_matrix_scan_if;
    import led_matrix_pkg::*;

    pat_sel_t  sel;
    logic [7:0] row;
    col_word_t col;
    pat_sel_t  pat_idx;
    logic      frame_start;

    modport master (output sel, input row, col, pat_idx, frame_start);
    modport slave  (input sel, output row, col, pat_idx, frame_start);

endinterface

// File: rtl/led_matrix_scan_pattern_rom.sv
// Combinational pattern lookup: (pattern, row) -> column word.
module led_pattern_rom
    import led_matrix_pkg::*;
(
    input  pat_sel_t  pat,
    input  row_idx_t  row,
    output col_word_t col
);

    assign col = PATTERN_ROM[pat][row];

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanning 8x8 LED matrix driver; the pattern changes only at frame boundaries.
// Optional GHOST_BLANK_EN blanks the columns on the last hold cycle of every row.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int ROW_HOLD       = 4,
    parameter bit ACTIVE_LOW_ROW = 1'b1
) (
    input logic              divided_clk,
    input logic              rst,
    led_matrix_scan_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(ROW_HOLD - 1);
    localparam logic [7:0] ROW_OFF   = ACTIVE_LOW_ROW ? 8'hFF : 8'h00;

    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    row_idx_t   row_idx;
    row_idx_t   row_nxt;
    pat_sel_t   pat_active;
    pat_sel_t   pat_nxt;
    logic       hold_last;
    logic       boundary;
    col_word_t  rom_col;
    col_word_t  col_nxt;

    always_comb begin
        hold_last = (hold_cnt == HOLD_LAST);
        boundary  = hold_last && (row_idx == 3'd7);
        hold_nxt  = hold_last ? 8'd0 : hold_cnt + 8'd1;
        row_nxt   = hold_last ? row_idx + 3'd1 : row_idx;
        pat_nxt   = boundary ? bus.sel : pat_active;
    end

    // Fed next-state indices so col lands on the same edge as row and pat_idx
    led_pattern_rom u_rom (
        .pat (pat_nxt),
        .row (row_nxt),
        .col (rom_col)
    );

`ifdef GHOST_BLANK_EN
    always_comb begin
        col_nxt = (hold_nxt == HOLD_LAST) ? '0 : rom_col;
    end

    always_ff @(posedge divided_clk) begin
        if (!rst) begin
            assert (ROW_HOLD >= 2)
                else $error("led_matrix_scan: ghost blanking needs ROW_HOLD >= 2");
        end
    end
`else
    always_comb begin
        col_nxt = rom_col;
    end
`endif

    always_ff @(posedge divided_clk) begin
        if (rst) begin
            hold_cnt        <= HOLD_LAST;
            row_idx         <= 3'd7;
            pat_active      <= '0;
            bus.row         <= ROW_OFF;
            bus.col         <= '0;
            bus.pat_idx     <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            hold_cnt        <= hold_nxt;
            row_idx         <= row_nxt;
            pat_active      <= pat_nxt;
            bus.row         <= (8'h01 << row_nxt) ^ ROW_OFF;
            bus.col         <= col_nxt;
            bus.pat_idx     <= pat_nxt;
            bus.frame_start <= boundary;
        end
    end

endmodule
